// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : line levels, parity selects and TX state encoding shared by UART TX/RX
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_serializer : load-enable LSB-first shift register, bit counter, word parity
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    input  logic                  cnt_en,
    output logic                  serial_bit,
    output logic                  done,
    output logic                  parity
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;
    logic                  parity_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg    <= '0;
            cnt      <= '0;
            parity_q <= 1'b0;
        end else if (load) begin
            shreg    <= load_data;
            cnt      <= '0;
            parity_q <= ^load_data;
        end else begin
            if (shift_en) begin
                shreg <= shreg >> 1;
            end
            // Saturate at the terminal count so done stays stable until the next load
            if (cnt_en && (cnt != LAST_CNT)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign serial_bit = shreg[0];
    assign done       = (cnt == LAST_CNT);
    assign parity     = parity_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_frame : one-bit-per-clock UART TX framer (start, data LSB first, parity, stop)
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    tx_state_e state;
    tx_state_e next_state;

    logic par_en_q;
    logic par_typ_q;
    logic tx_next;
    logic busy_next;
    logic load;
    logic shift_en;
    logic cnt_en;
    logic serial_bit;
    logic done;
    logic word_parity;
    logic parity_bit;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk        (CLK),
        .rst_n      (RST),
        .load       (load),
        .load_data  (P_DATA),
        .shift_en   (shift_en),
        .cnt_en     (cnt_en),
        .serial_bit (serial_bit),
        .done       (done),
        .parity     (word_parity)
    );

    assign parity_bit = (par_typ_q == PAR_ODD) ? ~word_parity : word_parity;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            TX_OUT    <= LINE_IDLE;
            BUSY      <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state  <= next_state;
            TX_OUT <= tx_next;
            BUSY   <= busy_next;
            if (load) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

    // The line value for the upcoming bit period is decided here so TX_OUT is a pure flop
    always_comb begin
        next_state = state;
        tx_next    = LINE_IDLE;
        load       = 1'b0;
        shift_en   = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (DATA_VALID) begin
                    next_state = START;
                    tx_next    = START_BIT;
                    load       = 1'b1;
                end
            end
            START: begin
                next_state = DATA;
                tx_next    = serial_bit;
                shift_en   = 1'b1;
            end
            DATA: begin
                if (done) begin
                    if (par_en_q) begin
                        next_state = PARITY;
                        tx_next    = parity_bit;
                    end else begin
                        next_state = STOP;
                    end
                end else begin
                    tx_next  = serial_bit;
                    shift_en = 1'b1;
                    cnt_en   = 1'b1;
                end
            end
            PARITY: begin
                next_state = STOP;
            end
            STOP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy_next = (next_state != IDLE);

endmodule
`default_nettype wire
